// File: rtl/shift_line_pkg.sv
// -----------------------------------------------------------------------------
// shift_line_pkg : shared mode encodings for the shift_line block
// Rev 1.0 : initial release
// -----------------------------------------------------------------------------
`default_nettype none

package shift_line_pkg;

  localparam int MODE_W    = 2;
  localparam int MIN_DEPTH = 2;
  localparam int MAX_DEPTH = 64;

  typedef enum logic [MODE_W-1:0] {
    HOLD  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2,
    ROT   = 2'd3
  } mode_e;

endpackage

`default_nettype wire

// File: rtl/shift_line_stage.sv
// -----------------------------------------------------------------------------
// shift_line_stage : one data+valid register with enable, flush and inverted q
// Rev 1.0 : initial release
// -----------------------------------------------------------------------------
`default_nettype none

module shift_line_stage
  import shift_line_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d_data,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q_data,
  output logic [WIDTH-1:0] q_n,
  output logic             q_valid
);

  logic [WIDTH-1:0] data_r;
  logic             valid_r;

  // Flush only drops the valid bit; the payload is left in place.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_r  <= '0;
      valid_r <= 1'b0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (en) begin
      data_r  <= d_data;
      valid_r <= d_valid;
    end
  end

  assign q_data  = data_r;
  assign q_n     = ~data_r;
  assign q_valid = valid_r;

endmodule

`default_nettype wire

// File: rtl/shift_line.sv
// -----------------------------------------------------------------------------
// shift_line : DEPTH-stage shift/load/rotate line with runtime tap and fill count
// Rev 1.0 : initial release
// -----------------------------------------------------------------------------
`default_nettype none

module shift_line
  import shift_line_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int TAPW  = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       flush,
  input  logic [1:0]                 mode,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  input  logic [DEPTH*WIDTH-1:0]     load_data,
  input  logic [TAPW-1:0]            tap_sel,
  output logic [WIDTH-1:0]           out_data,
  output logic [WIDTH-1:0]           out_n,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           tap_data,
  output logic                       tap_valid,
  output logic [DEPTH*WIDTH-1:0]     stages,
  output logic [$clog2(DEPTH+1)-1:0] fill_cnt
);

  localparam int CW = $clog2(DEPTH+1);

  mode_e            op;
  logic             stage_en;
  logic [WIDTH-1:0] q_data  [DEPTH];
  logic [WIDTH-1:0] q_n     [DEPTH];
  logic             q_valid [DEPTH];
  logic [CW-1:0]    fill_r;

  assign op       = mode_e'(mode);
  assign stage_en = en && (op != HOLD);

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] prev_data;
    logic             prev_valid;
    logic [WIDTH-1:0] nxt_data;
    logic             nxt_valid;

    // Stage 0 is fed by the serial input when shifting, by the tail when rotating.
    if (i == 0) begin : g_head
      assign prev_data  = (op == ROT) ? q_data[DEPTH-1]  : in_data;
      assign prev_valid = (op == ROT) ? q_valid[DEPTH-1] : in_valid;
    end else begin : g_body
      assign prev_data  = q_data[i-1];
      assign prev_valid = q_valid[i-1];
    end

    always_comb begin
      nxt_data  = prev_data;
      nxt_valid = prev_valid;
      if (op == LOAD) begin
        nxt_data  = load_data[i*WIDTH +: WIDTH];
        nxt_valid = 1'b1;
      end
    end

    shift_line_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (stage_en),
      .flush   (flush),
      .d_data  (nxt_data),
      .d_valid (nxt_valid),
      .q_data  (q_data[i]),
      .q_n     (q_n[i]),
      .q_valid (q_valid[i])
    );

    assign stages[i*WIDTH +: WIDTH] = q_data[i];
  end

  // Incremental count stays equal to the valid popcount: shift adds the
  // incoming valid and drops the outgoing one, rotate conserves it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_r <= '0;
    end else if (flush) begin
      fill_r <= '0;
    end else if (en) begin
      case (op)
        SHIFT:   fill_r <= CW'({1'b0, fill_r} + (CW+1)'(in_valid)
                               - (CW+1)'(q_valid[DEPTH-1]));
        LOAD:    fill_r <= CW'(DEPTH);
        default: fill_r <= fill_r;
      endcase
    end
  end

  always_comb begin
    tap_data  = '0;
    tap_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(tap_sel) == i) begin
        tap_data  = q_data[i];
        tap_valid = q_valid[i];
      end
    end
  end

  assign out_data  = q_data[DEPTH-1];
  assign out_n     = q_n[DEPTH-1];
  assign out_valid = q_valid[DEPTH-1];
  assign fill_cnt  = fill_r;

endmodule

`default_nettype wire

// File: tb/tb_shift_line.sv
// -----------------------------------------------------------------------------
// tb_shift_line : directed stimulus with a queued scoreboard for shift_line
// Rev 1.0 : initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_shift_line;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int TAPW  = 3;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   en;
  logic                   flush;
  logic [1:0]             mode;
  logic [WIDTH-1:0]       in_data;
  logic                   in_valid;
  logic [DEPTH*WIDTH-1:0] load_data;
  logic [TAPW-1:0]        tap_sel;
  logic [WIDTH-1:0]       out_data;
  logic [WIDTH-1:0]       out_n;
  logic                   out_valid;
  logic [WIDTH-1:0]       tap_data;
  logic                   tap_valid;
  logic [DEPTH*WIDTH-1:0] stages;
  logic [2:0]             fill_cnt;

  shift_line #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .TAPW  (TAPW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .flush     (flush),
    .mode      (mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .load_data (load_data),
    .tap_sel   (tap_sel),
    .out_data  (out_data),
    .out_n     (out_n),
    .out_valid (out_valid),
    .tap_data  (tap_data),
    .tap_valid (tap_valid),
    .stages    (stages),
    .fill_cnt  (fill_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] od;
    logic [7:0] on;
    logic       ov;
    logic [31:0] st;
    logic [2:0] fc;
    logic [7:0] td;
    logic       tv;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   total  = 0;
  int   passed = 0;

  task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, exp);
  endtask

  // Monitor: each expected snapshot is checked at the falling edge after its update.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      cmp(cur.name, "out_data",  32'(out_data),  32'(cur.od));
      cmp(cur.name, "out_n",     32'(out_n),     32'(cur.on));
      cmp(cur.name, "out_valid", 32'(out_valid), 32'(cur.ov));
      cmp(cur.name, "stages",    stages,         cur.st);
      cmp(cur.name, "fill_cnt",  32'(fill_cnt),  32'(cur.fc));
      cmp(cur.name, "tap_data",  32'(tap_data),  32'(cur.td));
      cmp(cur.name, "tap_valid", 32'(tap_valid), 32'(cur.tv));
    end
  end

  task automatic step(input logic r, input logic e, input logic f, input logic [1:0] m,
                      input logic [7:0] d, input logic v, input logic [2:0] ts,
                      input string nm, input logic [7:0] eod, input logic [7:0] eon,
                      input logic eov, input logic [31:0] est, input logic [2:0] efc,
                      input logic [7:0] etd, input logic etv);
    exp_t x;
    rst_n    = r;
    en       = e;
    flush    = f;
    mode     = m;
    in_data  = d;
    in_valid = v;
    tap_sel  = ts;
    @(posedge clk);
    #1;
    x.name = nm; x.od = eod; x.on = eon; x.ov = eov;
    x.st = est; x.fc = efc; x.td = etd; x.tv = etv;
    sb.push_back(x);
    @(negedge clk);
    #1;
  endtask

  initial begin
    load_data = 32'hA3A2A1A0;
    //    rst en fl mode  din  v  tap  name         od     on     ov  stages         fc  td     tv
    step(0, 0, 0, 2'd0, 8'h00, 0, 3'd0, "reset",     8'h00, 8'hFF, 0, 32'h00000000, 0, 8'h00, 0);
    step(1, 1, 0, 2'd1, 8'h11, 1, 3'd0, "shift1",    8'h00, 8'hFF, 0, 32'h00000011, 1, 8'h11, 1);
    step(1, 1, 0, 2'd1, 8'h22, 1, 3'd0, "shift2",    8'h00, 8'hFF, 0, 32'h00001122, 2, 8'h22, 1);
    step(1, 1, 0, 2'd1, 8'h33, 1, 3'd0, "shift3",    8'h00, 8'hFF, 0, 32'h00112233, 3, 8'h33, 1);
    step(1, 1, 0, 2'd1, 8'h44, 1, 3'd0, "shift4",    8'h11, 8'hEE, 1, 32'h11223344, 4, 8'h44, 1);
    step(1, 1, 0, 2'd0, 8'h55, 1, 3'd1, "hold_en",   8'h11, 8'hEE, 1, 32'h11223344, 4, 8'h33, 1);
    step(1, 1, 0, 2'd2, 8'h00, 0, 3'd2, "load",      8'hA3, 8'h5C, 1, 32'hA3A2A1A0, 4, 8'hA2, 1);
    step(1, 1, 0, 2'd3, 8'h99, 0, 3'd5, "rotate",    8'hA2, 8'h5D, 1, 32'hA2A1A0A3, 4, 8'h00, 0);
    step(1, 1, 0, 2'd1, 8'h55, 1, 3'd3, "shift_full",8'hA1, 8'h5E, 1, 32'hA1A0A355, 4, 8'hA1, 1);
    step(1, 0, 1, 2'd1, 8'h66, 1, 3'd2, "flush",     8'hA1, 8'h5E, 0, 32'hA1A0A355, 0, 8'hA0, 0);
    step(1, 0, 0, 2'd1, 8'h77, 1, 3'd2, "en_off",    8'hA1, 8'h5E, 0, 32'hA1A0A355, 0, 8'hA0, 0);
    step(1, 1, 0, 2'd1, 8'h01, 1, 3'd0, "alt1",      8'hA0, 8'h5F, 0, 32'hA0A35501, 1, 8'h01, 1);
    step(1, 1, 0, 2'd1, 8'h02, 0, 3'd0, "alt2",      8'hA3, 8'h5C, 0, 32'hA3550102, 1, 8'h02, 0);
    step(1, 1, 0, 2'd1, 8'h03, 1, 3'd0, "alt3",      8'h55, 8'hAA, 0, 32'h55010203, 2, 8'h03, 1);
    step(1, 1, 0, 2'd1, 8'h04, 0, 3'd0, "alt4",      8'h01, 8'hFE, 1, 32'h01020304, 2, 8'h04, 0);
    step(1, 1, 0, 2'd1, 8'h05, 1, 3'd0, "alt5",      8'h02, 8'hFD, 0, 32'h02030405, 2, 8'h05, 1);
    step(1, 1, 0, 2'd1, 8'h06, 0, 3'd0, "alt6",      8'h03, 8'hFC, 1, 32'h03040506, 2, 8'h06, 0);
    step(0, 1, 0, 2'd1, 8'h99, 1, 3'd0, "rst_shift", 8'h00, 8'hFF, 0, 32'h00000000, 0, 8'h00, 0);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      total++;
      $display("FAIL drain actual=%0d pending required=0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
